reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Multi-domain reset synchronizer/sequencer: synchronizes one async active-low
//  reset to clk_sync, holds it for a minimum stretch, then releases NUM_DOMAINS
//  synchronous resets in order 0..N-1, spaced RELEASE_GAP cycles apart. Also
//  accepts a synchronous soft-reset request. Sits at top level, feeding the
//  per-subsystem resets (e.g. memory ctrl before bus fabric before peripherals).
// PARAMETERS
//  SYNC_STAGES    2   flops in the deassertion synchronizer chain (>=2)
//  NUM_DOMAINS    4   number of sequenced reset outputs (>=1)
//  STRETCH_CYCLES 16  cycles held in reset after sync chain releases (>=1)
//  RELEASE_GAP    8   cycles between consecutive domain releases (>=1)
// PORTS
//  clk_sync        in   1            clock for synchronizing/sequencing
//  reset_async_n   in   1            asynchronous active-low reset input
//  soft_reset_req  in   1            sync to clk_sync; high = request re-sequence
//  reset_sync_n    out  NUM_DOMAINS  per-domain sync-deasserted active-low resets
//  reset_done      out  1            high once all domains released
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (reset_async_n). All flops
//    (chain, FSM, counters, outputs) reset async on reset_async_n low.
//  - Reset values: reset_sync_n = all 0, reset_done = 0, state HOLD, counts 0.
//  - Assertion is immediate (async, no clock needed); deassertion is synchronous.
//  - Outputs are registered directly; no combinational path to any output.
//  - FSM: HOLD -> STRETCH -> RELEASE -> DONE.
//    HOLD: sync chain shifts in 1; leave when chain last stage is 1.
//    STRETCH: count STRETCH_CYCLES cycles, all outputs 0.
//    RELEASE: release domain k, wait RELEASE_GAP, release k+1; after last -> DONE.
//    DONE: steady, all outputs 1, reset_done 1.
//  - Timing: E1 = first rising edge with reset_async_n high. Domain k goes high
//    at edge E(SYNC_STAGES+STRETCH_CYCLES+k*RELEASE_GAP); reset_done rises on the
//    same edge as domain N-1. Defaults: domains at E18,E26,E34,E42; done at E42.
//  - Once released, a domain stays high until next async or soft reset.
//  - soft_reset_req high at edge E in STRETCH/RELEASE/DONE: at E all
//    reset_sync_n <= 0, reset_done <= 0, stretch count cleared, state STRETCH.
//    Domain k then rises at edge E+STRETCH_CYCLES+k*RELEASE_GAP. Req held high
//    keeps restarting; timing counts from last edge with req high. Chain untouched.
//  - soft_reset_req ignored in HOLD (async reset dominates).
//  - reset_async_n low mid-sequence: all outputs 0 immediately, back to HOLD, full
//    sequence restarts from chain on release; no partial state retained.
//  - Glitch on reset_async_n shorter than a cycle still asserts outputs and
//    forces a full re-sequence.
//  - Counters sized $clog2(max(STRETCH_CYCLES,RELEASE_GAP)+1); domain index
//    $clog2(NUM_DOMAINS+1); counters never wrap (saturate on transition).
// STRUCTURE
//  - reset_sequencer_defs.vh: FSM state localparams (HOLD/STRETCH/RELEASE/DONE),
//    clog2 constant function; shared with future reset/clock-control blocks.
//  - One sub-module: reset_sync_chain (param STAGES; async-assert, sync-deassert
//    shift chain of 1s), instanced once for the input reset.
//  - Top holds FSM, stretch/gap counter, domain index, output register.
// TESTING
//  1 Defaults, reset_async_n low 5 cyc then high -> reset_sync_n 0000 until E18,
//    0001@E18, 0011@E26, 0111@E34, 1111@E42, reset_done 1@E42.
//  2 In DONE, soft_reset_req 1-cycle pulse at edge E -> outputs 0000, done 0 at E;
//    0001@E+16, 1111@E+40, done 1@E+40.
//  3 reset_async_n low mid-RELEASE (state 0011), between edges -> outputs 0000
//    before next edge; on release, full sequence repeats with timing of test 1.
//  4 soft_reset_req held high 10 cycles in DONE -> outputs 0 throughout;
//    0001 exactly 16 cycles after last edge with req high.
//  5 Params SYNC_STAGES=3, NUM_DOMAINS=1, STRETCH_CYCLES=1, RELEASE_GAP=1 ->
//    reset_sync_n=1 and reset_done=1 both at E4; soft_reset_req in HOLD ignored.
//  6 Sub-cycle low glitch on reset_async_n in DONE -> outputs drop async,
//    re-sequence per test 1; assert no X on outputs at any time after reset.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for reset/clock-control blocks.
// Provides the sequencer FSM state encoding plus constant-width helpers.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } rs_state_e;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..v-1 (minimum 1 bit).
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Async-assert, sync-deassert shift chain of 1s.
// Ports: clk, rst_n (async active-low), sync_n (synchronized release).
module reset_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_n
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = 1'b1;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_n = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: synchronizes reset_async_n, stretches it,
// then releases reset_sync_n[0..N-1] in order, RELEASE_GAP cycles apart.
// Ports: clk_sync, reset_async_n, soft_reset_req -> reset_sync_n, reset_done.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned RELEASE_GAP    = 8
) (
    input  logic                   clk_sync,
    input  logic                   reset_async_n,
    input  logic                   soft_reset_req,
    output logic [NUM_DOMAINS-1:0] reset_sync_n,
    output logic                   reset_done
);

    localparam int unsigned CW =
        clog2_u(max_u(STRETCH_CYCLES, RELEASE_GAP) + 1);
    localparam int unsigned IW = clog2_u(NUM_DOMAINS + 1);

    logic                   armed_n;
    logic                   release_next;
    rs_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   done_q, done_d;

    // The HOLD->STRETCH state flop is the final synchronizer stage, so the
    // chain itself is one flop shorter than SYNC_STAGES.
    reset_sync_chain #(
        .STAGES (SYNC_STAGES - 1)
    ) u_chain (
        .clk    (clk_sync),
        .rst_n  (reset_async_n),
        .sync_n (armed_n)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rst_d        = rst_q;
        done_d       = done_q;
        release_next = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                rst_d  = '0;
                done_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (armed_n) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
                    release_next = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                    release_next = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Domains release in order, so the output is a thermometer code.
        if (release_next) begin
            rst_d = (rst_q << 1) | NUM_DOMAINS'(1);
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
            if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RELEASE;
            end
        end

        // Soft request restarts the stretch; the chain is left alone.
        if (soft_reset_req && (state_q != ST_HOLD)) begin
            rst_d   = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_STRETCH;
        end
    end

    always_ff @(posedge clk_sync or negedge reset_async_n) begin
        if (!reset_async_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    assign reset_sync_n = rst_q;
    assign reset_done   = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (default and minimal params).
// Table-driven release timing plus hand-written soft/async corner cases.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [3:0] rsn;
    logic       done;
    logic       rst_b_n;
    logic       req_b;
    logic [0:0] rsn_b;
    logic       done_b;

    int checks   = 0;
    int failures = 0;
    bit x_arm    = 1'b0;

    typedef struct {
        int         edge_n;
        logic [3:0] rst;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    reset_sequencer u_dut (
        .clk_sync       (clk),
        .reset_async_n  (rst_n),
        .soft_reset_req (req),
        .reset_sync_n   (rsn),
        .reset_done     (done)
    );

    reset_sequencer #(
        .SYNC_STAGES    (3),
        .NUM_DOMAINS    (1),
        .STRETCH_CYCLES (1),
        .RELEASE_GAP    (1)
    ) u_dut_b (
        .clk_sync       (clk),
        .reset_async_n  (rst_b_n),
        .soft_reset_req (req_b),
        .reset_sync_n   (rsn_b),
        .reset_done     (done_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge 0 is "now"; edge k is the k-th following rising edge.
    task automatic run_table(input int lo, input int hi, input string tag);
        int e;
        e = 0;
        for (int i = lo; i <= hi; i++) begin
            while (e < vecs[i].edge_n) begin
                @(posedge clk);
                #1;
                e++;
            end
            check($sformatf("%s_E%0d_rst", tag, vecs[i].edge_n),
                  32'(rsn), 32'(vecs[i].rst));
            check($sformatf("%s_E%0d_done", tag, vecs[i].edge_n),
                  32'(done), 32'(vecs[i].done));
        end
    endtask

    always @(negedge clk) begin
        if (x_arm) begin
            checks++;
            if ($isunknown({rsn, done, rsn_b, done_b})) begin
                failures++;
                $display("FAIL no_x actual=%b required=known",
                         {rsn, done, rsn_b, done_b});
            end
        end
    end

    initial begin
        // Full sequence after async release: indices 0..10.
        vecs.push_back('{1,  4'h0, 1'b0});
        vecs.push_back('{2,  4'h0, 1'b0});
        vecs.push_back('{17, 4'h0, 1'b0});
        vecs.push_back('{18, 4'h1, 1'b0});
        vecs.push_back('{25, 4'h1, 1'b0});
        vecs.push_back('{26, 4'h3, 1'b0});
        vecs.push_back('{33, 4'h3, 1'b0});
        vecs.push_back('{34, 4'h7, 1'b0});
        vecs.push_back('{41, 4'h7, 1'b0});
        vecs.push_back('{42, 4'hF, 1'b1});
        vecs.push_back('{48, 4'hF, 1'b1});
        // Sequence after last soft-request edge: indices 11..17.
        vecs.push_back('{15, 4'h0, 1'b0});
        vecs.push_back('{16, 4'h1, 1'b0});
        vecs.push_back('{23, 4'h1, 1'b0});
        vecs.push_back('{24, 4'h3, 1'b0});
        vecs.push_back('{32, 4'h7, 1'b0});
        vecs.push_back('{39, 4'h7, 1'b0});
        vecs.push_back('{40, 4'hF, 1'b1});

        rst_n   = 1'b0;
        req     = 1'b0;
        rst_b_n = 1'b0;
        req_b   = 1'b0;
        ticks(3);
        check("reset_rst", 32'(rsn), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_b_rst", 32'(rsn_b), 32'h0);
        check("reset_b_done", 32'(done_b), 32'h0);
        x_arm = 1'b1;

        // Minimal params, soft request during HOLD must be ignored.
        req_b   = 1'b1;
        rst_b_n = 1'b1;
        ticks(1);
        check("t5_E1_rst", 32'(rsn_b), 32'h0);
        ticks(1);
        check("t5_E2_rst", 32'(rsn_b), 32'h0);
        req_b = 1'b0;
        ticks(1);
        check("t5_E3_rst", 32'(rsn_b), 32'h0);
        check("t5_E3_done", 32'(done_b), 32'h0);
        ticks(1);
        check("t5_E4_rst", 32'(rsn_b), 32'h1);
        check("t5_E4_done", 32'(done_b), 32'h1);

        // Test 1: basic release ordering.
        rst_n = 1'b1;
        run_table(0, 10, "t1");

        // Test 2: one-cycle soft pulse in DONE.
        req = 1'b1;
        ticks(1);
        req = 1'b0;
        check("t2_E_rst", 32'(rsn), 32'h0);
        check("t2_E_done", 32'(done), 32'h0);
        run_table(11, 17, "t2");

        // Test 3: async reset mid-release (state 0011), between edges.
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(26);
        check("t3_E26_rst", 32'(rsn), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t3_async_rst", 32'(rsn), 32'h0);
        check("t3_async_done", 32'(done), 32'h0);
        ticks(5);
        rst_n = 1'b1;
        run_table(0, 10, "t3");

        // Test 4: soft request held for 10 edges in DONE.
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            check($sformatf("t4_hold%0d_rst", i), 32'(rsn), 32'h0);
            check($sformatf("t4_hold%0d_done", i), 32'(done), 32'h0);
        end
        req = 1'b0;
        run_table(11, 17, "t4");

        // Test 6: sub-cycle glitch on reset_async_n in DONE.
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_glitch_rst", 32'(rsn), 32'h0);
        check("t6_glitch_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        run_table(0, 10, "t6");

        x_arm = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
